unary_decoder: RTL and testbench

UNARY_DECODER -- requirements
Module: unary_decoder

---
 rtl/unary_pkg.sv | 12 +
 rtl/unary_decoder.sv | 97 +++++++++
 tb/tb_unary_decoder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/unary_pkg.sv
// Shared types and defaults for the unary-stream decoder.
package unary_pkg;

  localparam int unsigned UNARY_INPUT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } unary_state_t;

endpackage

// File: rtl/unary_decoder.sv
// Counts the ones in a fixed-length unary bitstream and presents the count as
// a binary result with a valid/ready handshake, plus running min/max bounds.
module unary_decoder
  import unary_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = UNARY_INPUT_WIDTH,
  parameter int unsigned COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_bit,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] out_value,
  output logic [COUNT_WIDTH-1:0] lower_bound,
  output logic [COUNT_WIDTH-1:0] upper_bound,
  output logic                   drop_err
);

  localparam logic [COUNT_WIDTH-1:0] LAST_BEAT = COUNT_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_CNT  = COUNT_WIDTH'(INPUT_WIDTH);

  unary_state_t           state, state_nxt;
  logic [COUNT_WIDTH-1:0] beat_cnt, beat_cnt_nxt;
  logic [COUNT_WIDTH-1:0] ones_cnt, ones_cnt_nxt;
  logic [COUNT_WIDTH-1:0] out_value_nxt;
  logic                   drop_err_nxt;
  logic [COUNT_WIDTH-1:0] ones_inc;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign ones_inc  = ones_cnt + COUNT_WIDTH'(in_bit);

  // In HOLD the counters are already cleared, so the bounds collapse onto the result.
  assign lower_bound = (state == HOLD) ? out_value : ones_cnt;
  assign upper_bound = (state == HOLD) ? out_value : ones_cnt + (FULL_CNT - beat_cnt);

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      ones_cnt  <= '0;
      out_value <= '0;
      drop_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_cnt_nxt;
      ones_cnt  <= ones_cnt_nxt;
      out_value <= out_value_nxt;
      drop_err  <= drop_err_nxt;
    end
  end

  // Next-state logic; flush overrides everything, including a concurrent beat.
  always_comb begin
    state_nxt     = state;
    beat_cnt_nxt  = beat_cnt;
    ones_cnt_nxt  = ones_cnt;
    out_value_nxt = out_value;
    drop_err_nxt  = drop_err;

    if (flush) begin
      state_nxt     = IDLE;
      beat_cnt_nxt  = '0;
      ones_cnt_nxt  = '0;
      out_value_nxt = '0;
      drop_err_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (in_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              out_value_nxt = ones_inc;
              beat_cnt_nxt  = '0;
              ones_cnt_nxt  = '0;
              state_nxt     = HOLD;
            end else begin
              beat_cnt_nxt  = beat_cnt + COUNT_WIDTH'(1);
              ones_cnt_nxt  = ones_inc;
              state_nxt     = ACCUM;
            end
          end
        end
        HOLD: begin
          if (in_valid) drop_err_nxt = 1'b1;
          if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unary_decoder.sv
// Directed bench for unary_decoder at the default width and at INPUT_WIDTH=1.
module tb_unary_decoder;

  localparam int unsigned CW  = 6;
  localparam int unsigned CW1 = 1;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_bit, flush, out_ready;
  logic          in_ready, out_valid, drop_err;
  logic [CW-1:0] out_value, lower_bound, upper_bound;

  logic           reset1, in_valid1, in_bit1, flush1, out_ready1;
  logic           in_ready1, out_valid1, drop_err1;
  logic [CW1-1:0] out_value1, lower_bound1, upper_bound1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unary_decoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_value(out_value), .lower_bound(lower_bound),
    .upper_bound(upper_bound), .drop_err(drop_err)
  );

  unary_decoder #(.INPUT_WIDTH(1)) dut1 (
    .clk(clk), .reset(reset1), .in_valid(in_valid1), .in_bit(in_bit1),
    .in_ready(in_ready1), .flush(flush1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_value(out_value1), .lower_bound(lower_bound1),
    .upper_bound(upper_bound1), .drop_err(drop_err1)
  );

  // Present one cycle of input and settle just after the rising edge.
  task automatic cycle(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; reset1 = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || drop_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: rdy=%b vld=%b err=%b required 1 0 0", in_ready, out_valid, drop_err);
    end
    checks++;
    if (lower_bound !== 6'd0 || upper_bound !== 6'd32 || out_value !== 6'd0) begin
      errors++;
      $display("FAIL reset_bounds: lo=%0d hi=%0d val=%0d required 0 32 0", lower_bound, upper_bound, out_value);
    end
    @(posedge clk);
    #3;
    reset = 1'b1; reset1 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < 31; i++) cycle(1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || lower_bound !== 6'd31 || upper_bound !== 6'd32) begin
      errors++;
      $display("FAIL ones_31: vld=%b lo=%0d hi=%0d required 0 31 32", out_valid, lower_bound, upper_bound);
    end
    cycle(1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 6'd32 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ones_result: vld=%b val=%0d rdy=%b required 1 32 0", out_valid, out_value, in_ready);
    end
    checks++;
    if (lower_bound !== 6'd32 || upper_bound !== 6'd32) begin
      errors++;
      $display("FAIL ones_bounds: lo=%0d hi=%0d required 32 32", lower_bound, upper_bound);
    end
    out_ready = 1'b1;
    cycle(1'b0, 1'b0);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || upper_bound !== 6'd32 || lower_bound !== 6'd0) begin
      errors++;
      $display("FAIL ones_release: vld=%b rdy=%b lo=%0d hi=%0d required 0 1 0 32", out_valid, in_ready, lower_bound, upper_bound);
    end
  endtask

  // Beats 0..9 carry 4 ones (0,1,5,6), beats 10..25 are ones: 20 ones total.
  task automatic test_mixed();
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, (i < 10) ? ((i % 5) < 2) : (i < 26));
      if (i == 9) begin
        checks++;
        if (lower_bound !== 6'd4 || upper_bound !== 6'd26) begin
          errors++;
          $display("FAIL mixed_bounds10: lo=%0d hi=%0d required 4 26", lower_bound, upper_bound);
        end
      end
      if (i % 3 == 2 && i != 31) cycle(1'b0, 1'b1);
    end
    checks++;
    if (out_valid !== 1'b1 || out_value !== 6'd20) begin
      errors++;
      $display("FAIL mixed_result: vld=%b val=%0d required 1 20", out_valid, out_value);
    end
    out_ready = 1'b1;
    cycle(1'b0, 1'b0);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 32; i++) cycle(1'b1, i[0]);
    checks++;
    if (drop_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_pre_err: err=%b required 0", drop_err);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_value !== 6'd16 || drop_err !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%b val=%0d err=%b required 1 16 1", i, out_valid, out_value, drop_err);
      end
    end
    out_ready = 1'b1;
    cycle(1'b1, 1'b1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || lower_bound !== 6'd0 || upper_bound !== 6'd32 || drop_err !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: vld=%b lo=%0d hi=%0d err=%b required 0 0 32 1", out_valid, lower_bound, upper_bound, drop_err);
    end
    for (int i = 0; i < 32; i++) cycle(1'b1, i < 7);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 6'd7) begin
      errors++;
      $display("FAIL bp_next_stream: vld=%b val=%0d required 1 7", out_valid, out_value);
    end
    out_ready = 1'b1;
    cycle(1'b0, 1'b0);
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 17; i++) cycle(1'b1, 1'b1);
    checks++;
    if (lower_bound !== 6'd17 || upper_bound !== 6'd32 || drop_err !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: lo=%0d hi=%0d err=%b required 17 32 1", lower_bound, upper_bound, drop_err);
    end
    flush = 1'b1;
    cycle(1'b1, 1'b1);
    flush = 1'b0;
    checks++;
    if (lower_bound !== 6'd0 || upper_bound !== 6'd32 || drop_err !== 1'b0 || out_valid !== 1'b0 || out_value !== 6'd0) begin
      errors++;
      $display("FAIL flush_clear: lo=%0d hi=%0d err=%b vld=%b val=%0d required 0 32 0 0 0",
               lower_bound, upper_bound, drop_err, out_valid, out_value);
    end
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 6'd0 || upper_bound !== 6'd0) begin
      errors++;
      $display("FAIL flush_zeros: vld=%b val=%0d hi=%0d required 1 0 0", out_valid, out_value, upper_bound);
    end
    out_ready = 1'b1;
    cycle(1'b0, 1'b0);
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (lower_bound !== 6'd0 || upper_bound !== 6'd32 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: lo=%0d hi=%0d rdy=%b vld=%b required 0 32 1 0", lower_bound, upper_bound, in_ready, out_valid);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 22; i++) begin
      cycle(1'b1, 1'b1);
      if (out_valid) pulses++;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0);
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0 || lower_bound !== 6'd22) begin
      errors++;
      $display("FAIL async_no_result: pulses=%0d lo=%0d required 0 22", pulses, lower_bound);
    end
  endtask

  task automatic test_width1();
    checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || upper_bound1 !== 1'b1 || lower_bound1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_idle: vld=%b rdy=%b lo=%0d hi=%0d required 0 1 0 1", out_valid1, in_ready1, lower_bound1, upper_bound1);
    end
    in_valid1 = 1'b1;
    in_bit1   = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    in_bit1   = 1'b0;
    checks++;
    if (out_valid1 !== 1'b1 || out_value1 !== 1'b1 || in_ready1 !== 1'b0 || lower_bound1 !== 1'b1) begin
      errors++;
      $display("FAIL w1_hold: vld=%b val=%0d rdy=%b lo=%0d required 1 1 0 1", out_valid1, out_value1, in_ready1, lower_bound1);
    end
    out_ready1 = 1'b1;
    @(posedge clk);
    #1;
    out_ready1 = 1'b0;
    checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL w1_release: vld=%b rdy=%b required 0 1", out_valid1, in_ready1);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_bit = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_bit1 = 1'b0; flush1 = 1'b0; out_ready1 = 1'b0;
    test_reset();
    test_all_ones();
    test_mixed();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
